// File: rtl/btn_event_queue.sv
// btn_event_queue: syncs, debounces and queues button press events.
// Ports: clk, rst (sync, active-high), btn raw levels, rd_en pop strobe,
//   ovf_clr clears overflow; rd_data head mask (0 when empty), empty, full,
//   overflow (sticky drop flag), btn_level debounced button levels.
module btn_event_queue #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    input  logic             rd_en,
    input  logic             ovf_clr,
    output logic [N_BTN-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic [N_BTN-1:0] btn_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW:0]   DEPTH   = (AW + 1)'(FIFO_DEPTH);

    logic [N_BTN-1:0] s1, s2;
    logic [N_BTN-1:0] level, level_nxt;
    logic [N_BTN-1:0] evt;
    logic [CW-1:0]    cnt     [N_BTN];
    logic [CW-1:0]    cnt_nxt [N_BTN];

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive
    // mismatching samples; a rising acceptance is the press event.
    always_comb begin
        level_nxt = level;
        evt       = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != level[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    level_nxt[i] = s2[i];
                    evt[i]       = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            level <= '0;
            for (int i = 0; i < N_BTN; i++)
                cnt[i] <= '0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            level <= level_nxt;
            for (int i = 0; i < N_BTN; i++)
                cnt[i] <= cnt_nxt[i];
        end
    end

    assign btn_level = level;

    logic [N_BTN-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop, wr, drop;

    assign empty = (count == '0);
    assign full  = (count == DEPTH);
    assign push  = |evt;
    assign pop   = rd_en & ~empty;
    // When full, a push only fits if the head leaves on the same edge.
    assign wr    = push & (~full | pop);
    assign drop  = push & full & ~pop;

    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst && wr)
            mem[wr_ptr] <= evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            // A drop on the clearing edge keeps the flag set.
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule
